// File: rtl/serial_display_rx.sv
// Receiver for the three-wire 7-segment shift-out link: synchronizes the serial
// pins, rebuilds the 48-bit frame and decodes each digit back to BCD.
module serial_display_rx #(
   parameter int FRAME_BITS  = 48,
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic        i_serial_data,
   input  logic        i_serial_clk,
   input  logic        i_serial_latch,
   output logic [3:0]  o_hours_msb,
   output logic [3:0]  o_hours_lsb,
   output logic [3:0]  o_minutes_msb,
   output logic [3:0]  o_minutes_lsb,
   output logic [3:0]  o_seconds_msb,
   output logic [3:0]  o_seconds_lsb,
   output logic [5:0]  o_digit_valid,
   output logic [5:0]  o_dp,
   output logic [47:0] o_frame,
   output logic        o_frame_stb,
   output logic        o_frame_err
);

   localparam int          FW        = 48;
   localparam logic [5:0]  FRAME_CNT = 6'(FRAME_BITS);

   logic [SYNC_STAGES-1:0] data_sync_q;
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] latch_sync_q;
   logic                   clk_prev_q;
   logic                   latch_prev_q;

   logic [FW-1:0] shift_q, shift_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [23:0]   bcd_q, bcd_d;
   logic [5:0]    valid_q, valid_d;
   logic [5:0]    dp_q, dp_d;
   logic          stb_q, stb_d;
   logic          err_q, err_d;

   logic data_s, clk_rise_s, latch_rise_s;
   logic [4:0] dec_s;
   logic [7:0] byte_s;

   // {valid, bcd} for a {g..a} segment pattern; anything unrecognised is 4'hF/invalid
   function automatic logic [4:0] decode7(input logic [6:0] seg);
      case (seg)
         7'h3F:   decode7 = {1'b1, 4'd0};
         7'h06:   decode7 = {1'b1, 4'd1};
         7'h5B:   decode7 = {1'b1, 4'd2};
         7'h4F:   decode7 = {1'b1, 4'd3};
         7'h66:   decode7 = {1'b1, 4'd4};
         7'h6D:   decode7 = {1'b1, 4'd5};
         7'h7D:   decode7 = {1'b1, 4'd6};
         7'h07:   decode7 = {1'b1, 4'd7};
         7'h7F:   decode7 = {1'b1, 4'd8};
         7'h6F:   decode7 = {1'b1, 4'd9};
         default: decode7 = {1'b0, 4'hF};
      endcase
   endfunction

   assign data_s       = data_sync_q[SYNC_STAGES-1];
   assign clk_rise_s   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
   assign latch_rise_s = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;

   // Shift, count and latch handling; a same-cycle shift is applied before the latch check
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      bcd_d   = bcd_q;
      valid_d = valid_q;
      dp_d    = dp_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;
      dec_s   = 5'd0;
      byte_s  = 8'd0;
      if (i_en && clk_rise_s) begin
         shift_d = {shift_q[FW-2:0], data_s};
         if (cnt_q != 6'd63) begin
            cnt_d = cnt_q + 6'd1;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         shift_d = shift_q;
      end
      if (i_en && latch_rise_s) begin
         if (cnt_d == FRAME_CNT) begin
            frame_d = shift_d;
            stb_d   = 1'b1;
            for (int k = 0; k < 6; k++) begin
               byte_s = shift_d[FW-1-8*k -: 8];
               dec_s  = decode7(byte_s[6:0]);
               bcd_d[23-4*k -: 4] = dec_s[3:0];
               valid_d[5-k]       = dec_s[4];
               dp_d[5-k]          = byte_s[7];
            end
         end else begin
            err_d = 1'b1;
         end
         cnt_d = 6'd0;
      end else begin
         stb_d = 1'b0;
      end
   end

   // Synchronizers, edge history and all state registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         data_sync_q  <= '0;
         clk_sync_q   <= '0;
         latch_sync_q <= '0;
         clk_prev_q   <= 1'b0;
         latch_prev_q <= 1'b0;
         shift_q      <= 48'd0;
         cnt_q        <= 6'd0;
         frame_q      <= 48'd0;
         bcd_q        <= 24'hFFFFFF;
         valid_q      <= 6'd0;
         dp_q         <= 6'd0;
         stb_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
         latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
         clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
         latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         frame_q      <= frame_d;
         bcd_q        <= bcd_d;
         valid_q      <= valid_d;
         dp_q         <= dp_d;
         stb_q        <= stb_d;
         err_q        <= err_d;
      end
   end

   assign o_hours_msb   = bcd_q[23:20];
   assign o_hours_lsb   = bcd_q[19:16];
   assign o_minutes_msb = bcd_q[15:12];
   assign o_minutes_lsb = bcd_q[11:8];
   assign o_seconds_msb = bcd_q[7:4];
   assign o_seconds_lsb = bcd_q[3:0];
   assign o_digit_valid = valid_q;
   assign o_dp          = dp_q;
   assign o_frame       = frame_q;
   assign o_frame_stb   = stb_q;
   assign o_frame_err   = err_q;

endmodule

// File: tb/tb_serial_display_rx.sv
// Directed bench for serial_display_rx: good/short/long/invalid frames, enable
// gating and reset mid-frame, with hand-computed expected digits.
module tb_serial_display_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        sdata = 1'b0;
   logic        sclk = 1'b0;
   logic        slatch = 1'b0;
   logic [3:0]  hm, hl, mm, ml, sm, sl;
   logic [5:0]  valid, dp;
   logic [47:0] frame;
   logic        stb, err;

   int checks = 0;
   int errors = 0;

   // 12:34:56 with both minute dp bits set
   localparam logic [47:0] F1 = 48'h065BCFE66D7D;
   // 09:58:07 with seconds_lsb dp set
   localparam logic [47:0] F2 = 48'h3F6F6D7F3F87;
   // blank hours_msb, invalid 0x49 seconds_lsb, middle digits 7,8,9,0
   localparam logic [47:0] F3 = 48'h00077F6F3F49;

   serial_display_rx #(.FRAME_BITS(48), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
      .i_serial_data(sdata), .i_serial_clk(sclk), .i_serial_latch(slatch),
      .o_hours_msb(hm), .o_hours_lsb(hl), .o_minutes_msb(mm), .o_minutes_lsb(ml),
      .o_seconds_msb(sm), .o_seconds_lsb(sl), .o_digit_valid(valid), .o_dp(dp),
      .o_frame(frame), .o_frame_stb(stb), .o_frame_err(err)
   );

   always #10 clk = ~clk;

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends nbits MSB-first from f (zeros past bit 48); i_en low for bits in [off_lo, off_hi)
   task automatic send_bits(input logic [47:0] f, input int nbits, input int off_lo, input int off_hi);
      for (int i = 0; i < nbits; i++) begin
         en    = (i >= off_lo && i < off_hi) ? 1'b0 : 1'b1;
         sdata = (i < 48) ? f[47-i] : 1'b0;
         wait_cyc(4);
         sclk = 1'b1;
         wait_cyc(4);
         sclk = 1'b0;
      end
      en = 1'b1;
      wait_cyc(4);
   endtask

   // Pulses latch and counts strobes over the following cycles
   task automatic do_latch(output int n_stb, output int n_err, output int first_stb);
      n_stb = 0; n_err = 0; first_stb = -1;
      slatch = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         wait_cyc(1);
         if (i == 5) slatch = 1'b0;
         if (stb) begin
            n_stb++;
            if (first_stb < 0) first_stb = i;
         end
         if (err) n_err++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_cyc(3);
      checks++;
      if ({hm, hl, mm, ml, sm, sl} !== 24'hFFFFFF || valid !== 6'd0 || dp !== 6'd0 ||
          frame !== 48'd0 || stb !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset: digits=%h valid=%b dp=%b frame=%h stb=%b err=%b, want ffffff 0 0 0 0 0",
                  {hm, hl, mm, ml, sm, sl}, valid, dp, frame, stb, err);
      end
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_good_frame;
      int ns, ne, fs;
      send_bits(F1, 48, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 1 || ne !== 0 || fs !== 3) begin
         errors++;
         $display("FAIL good_strobe: stb=%0d err=%0d at=%0d, want 1 0 3", ns, ne, fs);
      end
      checks++;
      if ({hm, hl, mm, ml, sm, sl} !== 24'h123456 || valid !== 6'h3F || dp !== 6'b001100) begin
         errors++;
         $display("FAIL good_decode: digits=%h valid=%h dp=%b, want 123456 3f 001100",
                  {hm, hl, mm, ml, sm, sl}, valid, dp);
      end
      checks++;
      if (frame !== F1) begin
         errors++;
         $display("FAIL good_frame: frame=%h want %h", frame, F1);
      end
   endtask

   task automatic test_short_frame;
      int ns, ne, fs;
      send_bits(F2, 47, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 0 || ne !== 1) begin
         errors++;
         $display("FAIL short_strobe: stb=%0d err=%0d, want 0 1", ns, ne);
      end
      checks++;
      if (frame !== F1 || {hm, hl, mm, ml, sm, sl} !== 24'h123456 || dp !== 6'b001100) begin
         errors++;
         $display("FAIL short_hold: frame=%h digits=%h dp=%b, want %h 123456 001100",
                  frame, {hm, hl, mm, ml, sm, sl}, dp, F1);
      end
      send_bits(F2, 48, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 1 || ne !== 0 || frame !== F2 || {hm, hl, mm, ml, sm, sl} !== 24'h095807 ||
          valid !== 6'h3F || dp !== 6'b000001) begin
         errors++;
         $display("FAIL after_short: stb=%0d err=%0d frame=%h digits=%h valid=%h dp=%b, want 1 0 %h 095807 3f 000001",
                  ns, ne, frame, {hm, hl, mm, ml, sm, sl}, valid, dp, F2);
      end
   endtask

   task automatic test_long_frame;
      int ns, ne, fs;
      send_bits(F1, 70, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 0 || ne !== 1) begin
         errors++;
         $display("FAIL long_strobe: stb=%0d err=%0d, want 0 1", ns, ne);
      end
      checks++;
      if (frame !== F2 || {hm, hl, mm, ml, sm, sl} !== 24'h095807) begin
         errors++;
         $display("FAIL long_hold: frame=%h digits=%h, want %h 095807", frame, {hm, hl, mm, ml, sm, sl}, F2);
      end
   endtask

   task automatic test_invalid_digits;
      int ns, ne, fs;
      send_bits(F3, 48, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 1 || ne !== 0) begin
         errors++;
         $display("FAIL invalid_strobe: stb=%0d err=%0d, want 1 0", ns, ne);
      end
      checks++;
      if ({hm, hl, mm, ml, sm, sl} !== 24'hF7890F || valid !== 6'b011110 || dp !== 6'd0) begin
         errors++;
         $display("FAIL invalid_decode: digits=%h valid=%b dp=%b, want f7890f 011110 000000",
                  {hm, hl, mm, ml, sm, sl}, valid, dp);
      end
   endtask

   task automatic test_enable_gating;
      int ns, ne, fs;
      send_bits(F1, 48, 10, 20);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 0 || ne !== 1 || frame !== F3) begin
         errors++;
         $display("FAIL en_midframe: stb=%0d err=%0d frame=%h, want 0 1 %h", ns, ne, frame, F3);
      end
      // i_en low for the entire frame and its latch
      send_bits(F2, 48, 0, 48);
      en = 1'b0;
      do_latch(ns, ne, fs);
      en = 1'b1;
      checks++;
      if (ns !== 0 || ne !== 0 || frame !== F3 || {hm, hl, mm, ml, sm, sl} !== 24'hF7890F) begin
         errors++;
         $display("FAIL en_off_frame: stb=%0d err=%0d frame=%h digits=%h, want 0 0 %h f7890f",
                  ns, ne, frame, {hm, hl, mm, ml, sm, sl}, F3);
      end
   endtask

   task automatic test_reset_midframe;
      int ns, ne, fs;
      send_bits(F2, 20, 99, 99);
      rst_n = 1'b0;
      wait_cyc(3);
      checks++;
      if ({hm, hl, mm, ml, sm, sl} !== 24'hFFFFFF || valid !== 6'd0 || dp !== 6'd0 ||
          frame !== 48'd0 || stb !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: digits=%h valid=%b dp=%b frame=%h stb=%b err=%b, want ffffff 0 0 0 0 0",
                  {hm, hl, mm, ml, sm, sl}, valid, dp, frame, stb, err);
      end
      rst_n = 1'b1;
      wait_cyc(2);
      send_bits(F1, 48, 99, 99);
      do_latch(ns, ne, fs);
      checks++;
      if (ns !== 1 || ne !== 0 || fs !== 3 || frame !== F1 || {hm, hl, mm, ml, sm, sl} !== 24'h123456 ||
          valid !== 6'h3F || dp !== 6'b001100) begin
         errors++;
         $display("FAIL after_reset: stb=%0d err=%0d at=%0d frame=%h digits=%h valid=%h dp=%b, want 1 0 3 %h 123456 3f 001100",
                  ns, ne, fs, frame, {hm, hl, mm, ml, sm, sl}, valid, dp, F1);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_short_frame();
      test_long_frame();
      test_invalid_digits();
      test_enable_gating();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_display_rx.md
# serial_display_rx

Receiving end of the 7-segment display shift-out link. It samples the three-wire serial stream (data, shift clock, latch), which arrives asynchronously to i_clk, and rebuilds the 48-bit display frame. It then decodes each digit's segment pattern back to BCD with a decimal-point flag. It is used as a self-checking monitor on the clock's display outputs and as the front end of a second, daisy-chained display board.

## Interface
- FRAME_BITS, 48, bits per frame: 6 digits × 8 bits; any other latched count is a framing error
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2)
- i_clk  in  1  system clock (~50 MHz)
- i_reset_n  in  1  reset: synchronous, active-low; clock i_clk
- i_en  in  1  when low, shift/latch edges are ignored; synchronizers keep running and outputs hold
- i_serial_data  in  1  serial data, asynchronous
- i_serial_clk  in  1  shift clock, asynchronous; a bit is taken on each rising edge
- i_serial_latch  in  1  latch, asynchronous; a frame is committed on each rising edge
- o_hours_msb, o_hours_lsb, o_minutes_msb, o_minutes_lsb, o_seconds_msb, o_seconds_lsb  out  4 each  decoded BCD digits
- o_digit_valid  out  6  per-digit decode success; bit 5 = hours_msb … bit 0 = seconds_lsb
- o_dp  out  6  decimal-point bits, same ordering as o_digit_valid
- o_frame  out  48  raw committed frame
- o_frame_stb  out  1  one-cycle pulse when a good frame is committed
- o_frame_err  out  1  one-cycle pulse when a latch arrives with bit count ≠ FRAME_BITS

## Operation
- **Synchronizers.** Each of data, clk and latch passes through SYNC_STAGES flops. A one-flop history register on the synchronized clk and latch gives rise detection: rise = sync & ~prev.
- **Shift.** On a clk rise with i_en=1: shift_reg <= {shift_reg[46:0], data_sync}.
  - The first bit sent ends up in bit 47.
  - bit_cnt (6 bits) increments and saturates at 63.
- **Byte layout.** Byte k occupies frame bits [47-8k : 40-8k].
  - k=0 hours_msb, 1 hours_lsb, 2 minutes_msb, 3 minutes_lsb, 4 seconds_msb, 5 seconds_lsb.
  - Within a byte: bit7 = dp, bits6..0 = segments g,f,e,d,c,b,a. Segments are active-high.
- **Decode, per digit.** Patterns are {g..a} in hex:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. Each of these sets valid=1.
  - Any other pattern, including blank 0x00, gives 4'hF with valid=0.
- **Latch, good count.** On a latch rise with i_en=1 and bit_cnt == FRAME_BITS, in a single edge:
  - o_frame <= shift_reg
  - BCD, valid and dp outputs <= decode(shift_reg)
  - o_frame_stb <= 1
- **Latch, bad count.** If bit_cnt ≠ FRAME_BITS:
  - o_frame_err <= 1
  - o_frame, BCD, valid and dp hold their previous values.
- **After any latch rise,** good or bad, bit_cnt <= 0. shift_reg is not cleared.
- **Simultaneous clk rise and latch rise in one cycle.** The bit is shifted and counted first. The latch check and capture then use the post-shift count and contents.
- **i_en=0.** Rises are discarded, not deferred. Raising i_en mid-frame leaves bit_cnt short, so the next latch flags an error.

## Timing
- **Reset values.**
  - BCD outputs 4'hF; o_digit_valid 0; o_dp 0; o_frame 0; o_frame_stb 0; o_frame_err 0.
  - shift_reg 0, bit_cnt 0, synchronizers 0, history flops 0.
- **Reset behaviour.** Reset mid-frame discards the partial frame. A latch rise in the reset cycle is ignored.
- **Latency.** A pin transition on clk or latch acts at the (SYNC_STAGES+1)th i_clk rising edge after it. Outputs and strobes become visible in the cycle after that edge.
- **Strobes.** o_frame_stb and o_frame_err are exactly one cycle wide and never both high.
- **Input constraints.**
  - Serial clk and latch high and low times must each be ≥ SYNC_STAGES+2 i_clk cycles. At 1 MHz shift against 50 MHz this holds with wide margin.
  - Data must be stable from SYNC_STAGES+1 cycles before to 1 cycle after each clk rise.

## Test plan
- **Good frame.** Reset, then send 48 bits encoding 12:34:56 with the colon dp bits on minutes set, then latch.
  - Expect digits 1,2,3,4,5,6, o_digit_valid=6'h3F, o_dp=6'b001100.
  - Expect a single o_frame_stb pulse at latch+3 cycles, and o_frame equal to the sent bits.
- **Short frame.** Send 47 bits, then latch.
  - Expect an o_frame_err pulse with outputs unchanged from the previous frame.
  - A following 48-bit frame is accepted normally.
- **Long frame.** Send 70 bits, then latch.
  - Expect o_frame_err (count saturated at 63) and outputs held.
- **Invalid and blank digits.** Send a frame with hours_msb blank (0x00) and seconds_lsb = 0x49.
  - Those two digits read 4'hF with valid bits 5 and 0 low. The other digits decode correctly.
- **Enable gating.** Drop i_en for 10 shift clocks mid-frame.
  - Expect o_frame_err at the latch.
  - With i_en=0 throughout a full frame, no strobe fires and outputs hold.
- **Reset mid-frame.** Assert reset after 20 bits, release, send a full 48-bit frame and latch.
  - Expect all reset values during reset, then a correct decode with a single o_frame_stb.
